// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display slice.
// Segment patterns are active-high, bit0 = a ... bit6 = g.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Clock cycles per display sample.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned upd_hz);
        return clk_hz / upd_hz;
    endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// One decimal digit (plus blank request) to an active-high segment pattern.
// Codes 10..31 are not decimal digits and render as a dash.
module bcd_a_7seg
    import display_pkg::*;
(
    input  logic [4:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; blank overrides everything.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                5'd0:    seg = SEG_0;
                5'd1:    seg = SEG_1;
                5'd2:    seg = SEG_2;
                5'd3:    seg = SEG_3;
                5'd4:    seg = SEG_4;
                5'd5:    seg = SEG_5;
                5'd6:    seg = SEG_6;
                5'd7:    seg = SEG_7;
                5'd8:    seg = SEG_8;
                5'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/display_7seg_digitos.sv
// Six-digit seven-segment display driver. Samples the digit inputs at a slow
// refresh rate (or on demand), holds them, blanks leading zeros and drives
// registered segment outputs.
module display_7seg_digitos
    import display_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned UPDATE_HZ   = 4,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] digit0,
    input  logic [4:0] digit1,
    input  logic [4:0] digit2,
    input  logic [4:0] digit3,
    input  logic [4:0] digit4,
    input  logic [4:0] digit5,
    input  logic       enable,
    input  logic       freeze,
    input  logic       load,
    input  logic       blank_ceros,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       update_tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, UPDATE_HZ);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [6:0] OUT_BLANK = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_int;
    logic              capture;
    logic [5:0][4:0]   digits_in;
    logic [5:0][4:0]   hold_q;
    logic              update_tick_q;
    logic [5:0]        lead_blank;
    logic [5:0][6:0]   seg_pat;
    logic [5:0][6:0]   hex_q, hex_d;

    assign digits_in = {digit5, digit4, digit3, digit2, digit1, digit0};

    assign tick_int = enable && (cnt_q == CW'(DIV - 1));
    // load captures regardless of freeze/enable; a frozen tick only wraps cnt.
    assign capture  = load || (tick_int && !freeze);

    // Prescaler next state: load restarts the sample period.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick_int ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler, hold registers and capture pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            hold_q        <= '0;
            update_tick_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            update_tick_q <= capture;
            if (capture) begin
                hold_q <= digits_in;
            end
        end
    end

    // Leading-zero blanking: walk from digit5 down, stop at the first non-zero
    // (invalid codes count as non-zero). digit0 always shows.
    always_comb begin
        logic run;
        run        = blank_ceros;
        lead_blank = '0;
        for (int i = 5; i >= 1; i--) begin
            run           = run && (hold_q[i] == 5'd0);
            lead_blank[i] = run;
        end
    end

    for (genvar g = 0; g < 6; g++) begin : gen_dec
        bcd_a_7seg u_dec (
            .digit (hold_q[g]),
            .blank (lead_blank[g]),
            .seg   (seg_pat[g])
        );
    end

    // Apply board polarity.
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < 6; i++) begin
            hex_d[i] = ACTIVE_LOW ? ~seg_pat[i] : seg_pat[i];
        end
    end

    // Registered segment outputs, blank out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q <= {6{OUT_BLANK}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign hex4        = hex_q[4];
    assign hex5        = hex_q[5];
    assign update_tick = update_tick_q;

endmodule

// File: tb/tb_display_7seg_digitos.sv
// Bench for display_7seg_digitos: directed scenarios followed by random
// traffic, checked against a behavioural model and a capture-timing scoreboard.
module tb_display_7seg_digitos;

    localparam int unsigned CLK_HZ = 20;
    localparam int unsigned UPD_HZ = 2;
    localparam int          DIV    = CLK_HZ / UPD_HZ;

    logic            clk = 1'b0;
    logic            reset;
    logic [5:0][4:0] dig;
    logic            enable, freeze, load, blank_ceros;
    logic [6:0]      hex0, hex1, hex2, hex3, hex4, hex5;
    logic            update_tick;

    int n_checks = 0;
    int n_fail   = 0;

    display_7seg_digitos #(
        .CLK_FREQ_HZ (CLK_HZ),
        .UPDATE_HZ   (UPD_HZ),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit0      (dig[0]),
        .digit1      (dig[1]),
        .digit2      (dig[2]),
        .digit3      (dig[3]),
        .digit4      (dig[4]),
        .digit5      (dig[5]),
        .enable      (enable),
        .freeze      (freeze),
        .load        (load),
        .blank_ceros (blank_ceros),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .update_tick (update_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Whole display image (active-low) for a held number.
    function automatic logic [5:0][6:0] render(input logic [5:0][4:0] d, input logic bz);
        logic [5:0][6:0] r;
        int top;
        top = 0;
        for (int i = 1; i < 6; i++) if (d[i] != 0) top = i;
        for (int i = 0; i < 6; i++) begin
            if (bz && i > top) r[i] = ~7'h00;
            else               r[i] = ~glyph(int'(d[i]));
        end
        return r;
    endfunction

    int              cyc = 0;
    int              m_phase = 0;
    logic [5:0][4:0] m_hold = '0;
    logic [5:0][6:0] exp_hex = '0;
    logic            armed = 1'b0;
    logic            m_tick, m_cap;
    int              sb_q[$];

    always_comb begin
        m_tick = enable && ((m_phase % DIV) == DIV - 1);
        m_cap  = !reset && (load || (m_tick && !freeze));
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            armed   <= 1'b1;
            m_phase <= 0;
            m_hold  <= '0;
            exp_hex <= {6{7'h7F}};
        end else begin
            exp_hex <= render(m_hold, blank_ceros);
            if (m_cap) begin
                m_hold <= dig;
                sb_q.push_back(cyc + 1);
            end
            if (load)        m_phase <= 0;
            else if (enable) m_phase <= m_phase + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(exp_hex));
                if (update_tick === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_tick", 64'(update_tick), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("tick_cycle", 64'(cyc), 64'(e));
                    end
                end else if (sb_q.size() > 0 && sb_q[0] <= cyc) begin
                    e = sb_q.pop_front();
                    chk("missing_tick", 64'(update_tick), 64'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        int k;
        k = 0;
        while ((m_phase % DIV) != p && k < 4 * DIV) begin
            @(negedge clk);
            k++;
        end
        if ((m_phase % DIV) != p) chk("wait_phase_timeout", 64'(m_phase % DIV), 64'(p));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; freeze = 1'b0; load = 1'b0; blank_ceros = 1'b1;
        dig = {5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3};
        step(2);
        chk("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        chk("reset_tick", 64'(update_tick), 64'd0);
        reset = 1'b0;

        // Periodic capture of 000123 with blanking.
        step(15);
        chk("s1_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}));
        step(10);

        // Frozen display while digits churn.
        freeze = 1'b1;
        for (int i = 0; i < 25; i++) begin
            for (int j = 0; j < 6; j++) dig[j] = 5'($urandom_range(0, 9));
            step(1);
        end
        freeze = 1'b0;
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < 6; j++) dig[j] = 5'($urandom_range(0, 9));
            step(1);
        end

        // Immediate load at cnt = 4.
        wait_phase(4);
        dig  = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4};
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("load_tick", 64'(update_tick), 64'd1);
        step(1);
        chk("load_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}));
        step(12);

        // Invalid digit stops blanking and shows a dash.
        dig = {5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0};
        step(12);
        chk("dash_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40}));

        // Zero value, then blanking switched off without a capture.
        dig = '0;
        step(12);
        chk("zero_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        blank_ceros = 1'b0;
        step(1);
        chk("zero_noblank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h40}}));

        // Reset mid-count with load asserted.
        wait_phase(7);
        reset = 1'b1; load = 1'b1;
        dig = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        step(1);
        chk("rst_load_tick", 64'(update_tick), 64'd0);
        chk("rst_load_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        reset = 1'b0; load = 1'b0;
        step(14);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 6; j++)
                dig[j] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            enable = ($urandom_range(0, 7) != 0);
            freeze = ($urandom_range(0, 5) == 0);
            load   = ($urandom_range(0, 19) == 0);
            reset  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) blank_ceros = ~blank_ceros;
            step(1);
        end
        reset = 1'b0; load = 1'b0; freeze = 1'b0; enable = 1'b1;
        step(3 * DIV);
        if (sb_q.size() != 0) chk("pending_ticks", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
